// File: rtl/ddr4_reader.sv
// Kalman filter input stage: fetches X, P and Z from DDR4 with AXI4 read bursts
// and unpacks each 512-bit beat into eight 64-bit elements.
module ddr4_reader #(
  parameter int          STATE_DIM   = 12,
  parameter int          MEASURE_DIM = 6,
  parameter logic [31:0] ADDR_X_BASE = 32'h0010_0000,
  parameter logic [31:0] ADDR_P_BASE = 32'h0020_0000,
  parameter logic [31:0] ADDR_Z_BASE = 32'h0030_0000
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  output logic [STATE_DIM-1:0][63:0]               X_k_out,
  output logic [STATE_DIM-1:0][STATE_DIM-1:0][63:0] P_k_out,
  output logic [MEASURE_DIM-1:0][63:0]             Z_k_out,
  output logic [31:0]                              axi_araddr,
  output logic [7:0]                               axi_arlen,
  output logic [2:0]                               axi_arsize,
  output logic [1:0]                               axi_arburst,
  output logic                                     axi_arvalid,
  input  logic                                     axi_arready,
  input  logic [511:0]                             axi_rdata,
  input  logic [1:0]                               axi_rresp,
  input  logic                                     axi_rlast,
  input  logic                                     axi_rvalid,
  output logic                                     axi_rready
);
  // state | meaning
  // IDLE  | waiting for start
  // AR_*  | address of X / P / Z burst offered, waiting for arready
  // R_*   | receiving beats of X / P / Z
  // DONE  | one-cycle done pulse, then IDLE
  localparam int P_SIZE  = STATE_DIM * STATE_DIM;
  localparam int X_BEATS = (STATE_DIM + 7) / 8;
  localparam int P_BEATS = (P_SIZE + 7) / 8;
  localparam int Z_BEATS = (MEASURE_DIM + 7) / 8;
  localparam int CNT_W   = $clog2(P_BEATS + 1);
  localparam int E_W     = CNT_W + 3;
  localparam int XI_W    = $clog2(STATE_DIM);
  localparam int PI_W    = $clog2(P_SIZE);
  localparam int ZI_W    = $clog2(MEASURE_DIM);

  typedef enum logic [2:0] {IDLE, AR_X, R_X, AR_P, R_P, AR_Z, R_Z, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        last_cnt;
  logic                    last_beat;
  logic                    beat_ok;
  logic [E_W-1:0]          lane_e [8];
  logic [P_SIZE-1:0][63:0] p_q;

  assign axi_arsize  = 3'b110;
  assign axi_arburst = 2'b01;
  assign P_k_out     = p_q;

  always_comb begin
    last_cnt = '0;
    case (state)
      R_X:     last_cnt = CNT_W'(X_BEATS - 1);
      R_P:     last_cnt = CNT_W'(P_BEATS - 1);
      R_Z:     last_cnt = CNT_W'(Z_BEATS - 1);
      default: last_cnt = '0;
    endcase
  end

  assign last_beat = (beat_cnt == last_cnt);
  assign beat_ok   = axi_rvalid && axi_rready;

  // element index carried by each lane of the current beat
  always_comb begin
    for (int l = 0; l < 8; l++) lane_e[l] = {beat_cnt, 3'(l)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            err         <= 1'b0;
            beat_cnt    <= '0;
            axi_araddr  <= ADDR_X_BASE;
            axi_arlen   <= 8'(X_BEATS - 1);
            axi_arvalid <= 1'b1;
            busy        <= 1'b1;
            state       <= AR_X;
          end
        end
        AR_X, AR_P, AR_Z: begin
          if (axi_arvalid && axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            case (state)
              AR_X:    state <= R_X;
              AR_P:    state <= R_P;
              default: state <= R_Z;
            endcase
          end
        end
        default: begin
          if (beat_ok) begin
            // rlast is only cross-checked; the beat counter decides phase end
            if (axi_rresp != 2'b00 || axi_rlast != last_beat) err <= 1'b1;
            if (last_beat) begin
              beat_cnt   <= '0;
              axi_rready <= 1'b0;
              case (state)
                R_X: begin
                  axi_araddr  <= ADDR_P_BASE;
                  axi_arlen   <= 8'(P_BEATS - 1);
                  axi_arvalid <= 1'b1;
                  state       <= AR_P;
                end
                R_P: begin
                  axi_araddr  <= ADDR_Z_BASE;
                  axi_arlen   <= 8'(Z_BEATS - 1);
                  axi_arvalid <= 1'b1;
                  state       <= AR_Z;
                end
                default: begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              endcase
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_k_out <= '0;
      p_q     <= '0;
      Z_k_out <= '0;
    end else if (beat_ok) begin
      for (int l = 0; l < 8; l++) begin
        if (state == R_X && lane_e[l] < E_W'(STATE_DIM))
          X_k_out[lane_e[l][XI_W-1:0]] <= axi_rdata[l*64 +: 64];
        if (state == R_P && lane_e[l] < E_W'(P_SIZE))
          p_q[lane_e[l][PI_W-1:0]] <= axi_rdata[l*64 +: 64];
        if (state == R_Z && lane_e[l] < E_W'(MEASURE_DIM))
          Z_k_out[lane_e[l][ZI_W-1:0]] <= axi_rdata[l*64 +: 64];
      end
    end
  end

endmodule

// File: doc/ddr4_reader.md
Name: ddr4_reader

Overview:
- Upstream input stage of the Kalman filter. Fetches the prior state vector X, covariance P and measurement vector Z from DDR4 over an AXI4-Full read channel (512-bit data).
- Unpacks the 512-bit beats into arrays of 64-bit doubles and presents them to the filter core.
- Pulses done when all three operands are loaded; the done pulse is the core's start trigger.

Parameters:
- STATE_DIM, 12, state dimension (X length; P is STATE_DIM x STATE_DIM).
- MEASURE_DIM, 6, measurement dimension (Z length).
- ADDR_X_BASE, 32'h0010_0000, DDR byte address of X.
- ADDR_P_BASE, 32'h0020_0000, DDR byte address of P (row-major).
- ADDR_Z_BASE, 32'h0030_0000, DDR byte address of Z.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load X, P, Z. Ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse; all arrays are valid.
- err  out  1  sticky error flag; cleared on the next accepted start.
- X_k_out  out  [STATE_DIM-1:0][63:0]  loaded state vector.
- P_k_out  out  [STATE_DIM-1:0][STATE_DIM-1:0][63:0]  loaded covariance.
- Z_k_out  out  [MEASURE_DIM-1:0][63:0]  loaded measurement.
- axi_araddr  out  32  burst start address.
- axi_arlen  out  8  beats-1.
- axi_arsize  out  3  constant 3'b110 (64 bytes per beat).
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_arvalid  out  1  read-address valid.
- axi_arready  in  1  read-address ready.
- axi_rdata  in  512  read data.
- axi_rresp  in  2  read response.
- axi_rlast  in  1  last beat of burst.
- axi_rvalid  in  1  read-data valid.
- axi_rready  out  1  read-data ready.

Behaviour:
- Derived burst lengths: X_BEATS=ceil(STATE_DIM/8)=2, P_BEATS=ceil(STATE_DIM²/8)=18, Z_BEATS=ceil(MEASURE_DIM/8)=1. axi_arlen = BEATS-1 of the current phase.
- Reset values (async, rst_n=0): state IDLE; araddr, arvalid, rready, busy, done, err = 0; all output array elements = 0.
- FSM states: IDLE, AR_X, R_X, AR_P, R_P, AR_Z, R_Z, DONE.
- IDLE:
  - On start=1, clear err and beat_cnt, load araddr=ADDR_X_BASE, assert arvalid, go to AR_X.
  - First arvalid is seen the cycle after start.
- AR_*:
  - arvalid is held high, and araddr/arlen held stable, until arvalid&&arready. arvalid is never withdrawn without a handshake.
  - On handshake: drop arvalid, assert rready, go to R_*.
- R_*:
  - rready=1 throughout. Each beat is accepted on rvalid&&rready.
  - Lane l (rdata[l*64 +: 64]) maps to element e = beat_cnt*8 + l. Lanes with e ≥ vector/matrix size are discarded.
  - For P, row = e / STATE_DIM and col = e % STATE_DIM.
  - beat_cnt increments per accepted beat.
- Phase end:
  - The phase ends on the accepted beat where beat_cnt == BEATS-1; beat_cnt is authoritative.
  - On that beat: rready drops next cycle, beat_cnt clears, and araddr is loaded with the next base with arvalid asserted (R_X→AR_P, R_P→AR_Z, R_Z→DONE).
- Error conditions (all set err; the sequence continues to completion):
  - rresp≠2'b00 on any accepted beat.
  - rlast=1 on a beat other than the last.
  - rlast=0 on the last beat.
- DONE: done=1 for exactly one cycle, busy drops that same cycle, return to IDLE.
  - Back-to-back is allowed: a start in the cycle after DONE is accepted.
- Output arrays:
  - Each element updates only on the beat that carries it.
  - Elements hold their values between transactions. A new load overwrites elements progressively, so consumers sample only after done.
- start while busy: ignored, no queuing.
- Reset mid-operation: immediately returns to IDLE with arvalid=0 and rready=0. Outstanding AXI beats after reset are the interconnect's responsibility.
- Total latency with zero-wait slave: 3 AR cycles + 21 data beats + 1 DONE cycle ≈ 25 cycles from start to done.

Test Plan:
- Zero-wait slave; memory word at byte address A holds the value A. Pulse start → ARs issued to 0x100000/len1, 0x200000/len17, 0x300000/len0, in that order. X_k_out[9]=0x100048, P_k_out[11][11]=0x200478, Z_k_out[5]=0x300028. done pulses once; err=0.
- arready held low for 5 cycles on each AR → arvalid stays high with araddr stable. Result matches the zero-wait case, with done 15 cycles later.
- rvalid toggling every other cycle during P → all 144 P elements correct. beat_cnt advances only on handshakes.
- rresp=2'b10 on P beat 4 → err=1 at done; all other data still loaded. The next start clears err.
- rlast asserted on X beat 0 → err=1; FSM still reads beat 1 and completes.
- rst_n asserted low mid-R_P, then released → all outputs 0, state IDLE. A subsequent start completes normally.
